// File: rtl/dense_drain_ctrl_if.sv
// Valid/ready output stream from the dense drain controller to the output-buffer writer.
// Each beat carries one result word and its destination address.
interface dense_drain_ctrl_if #(
  parameter int unsigned WID    = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              valid;
  logic              ready;
  logic [WID-1:0]    data;
  logic [ADDR_W-1:0] addr;

  modport master (output valid, output data, output addr, input ready);
  modport slave  (input valid, input data, input addr, output ready);
endinterface

// File: rtl/dense_drain_ctrl.sv
// Freezes the PE-array dense outputs with a one-cycle latch pulse, then streams the
// requested number of latched words to the output buffer over a valid/ready port.
`ifndef N_PE
`define N_PE 8
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

module dense_drain_ctrl #(
  parameter int unsigned N_PE   = `N_PE,
  parameter int unsigned WID    = `WID_PE_BITS,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = $clog2(N_PE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     count,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 abort,
  output logic                 dense_latch,
  output logic [IDX_W-1:0]     dense_rd_addr,
  input  logic [WID-1:0]       pea_data,
  dense_drain_ctrl_if.master   out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StLatch, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WID-1:0]    data_q, data_d;
  logic              valid_q, valid_d;
  logic              load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    load    = 1'b0;

    // Abort wins everywhere; in IDLE it simply swallows a coincident start.
    if (abort) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_d   = (count > IDX_W'(N_PE)) ? IDX_W'(N_PE) : count;
            base_d  = base_addr;
            state_d = (count == '0) ? StDone : StLatch;
          end
        end
        StLatch: begin
          idx_d   = '0;
          state_d = StDrain;
        end
        StDrain: begin
          load = (idx_q < cnt_q) && (!valid_q || out.ready);
          if (load) begin
            data_d  = pea_data;
            addr_d  = base_q + ADDR_W'(idx_q);
            valid_d = 1'b1;
            idx_d   = idx_q + 1'b1;
          end else if ((idx_q == cnt_q) && valid_q && out.ready) begin
            valid_d = 1'b0;
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign dense_latch   = (state_q == StLatch) && !abort;
  assign done          = (state_q == StDone) && !abort;
  assign busy          = (state_q != StIdle);
  assign dense_rd_addr = idx_q;
  assign out.valid     = valid_q;
  assign out.data      = data_q;
  assign out.addr      = addr_q;

endmodule

// File: tb/tb_dense_drain_ctrl.sv
// Directed bench for dense_drain_ctrl: cycle-accurate checks of latch, stream, done,
// backpressure, clamping, address wrap, ignored start, abort and asynchronous reset.
module tb_dense_drain_ctrl;
  localparam int NPE = 8;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [IW-1:0] count;
  logic [15:0]   base_addr;
  logic          dense_latch;
  logic [IW-1:0] dense_rd_addr;
  logic [15:0]   pea_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dense_drain_ctrl_if #(.WID(16), .ADDR_W(16)) out_if ();

  dense_drain_ctrl #(.N_PE(NPE), .WID(16), .ADDR_W(16), .IDX_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .count         (count),
    .base_addr     (base_addr),
    .abort         (abort),
    .dense_latch   (dense_latch),
    .dense_rd_addr (dense_rd_addr),
    .pea_data      (pea_data),
    .out           (out_if),
    .busy          (busy),
    .done          (done)
  );

  // PE-array model: live accumulators captured into the latch on dense_latch.
  logic [15:0] acc [NPE];
  logic [15:0] lat [NPE];
  always @(posedge clk) begin
    if (dense_latch) for (int i = 0; i < NPE; i++) lat[i] <= acc[i];
  end
  assign pea_data = (dense_rd_addr < IW'(NPE)) ? lat[dense_rd_addr[2:0]] : 16'hDEAD;

  int n_tests = 0;
  int n_fail  = 0;

  int stall_lo, stall_hi, ign_cyc, abort_cyc;
  bit rand_rdy;
  int latch_cnt, latch_cyc, done_cnt, done_cyc, busy_cnt, stall_cnt, stable_err;
  logic [15:0] acc_data[$];
  logic [15:0] acc_addr[$];
  int          acc_cyc[$];
  logic        vlog [64];
  logic        blog [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_acc(input logic [15:0] b, input logic [15:0] step);
    for (int i = 0; i < NPE; i++) acc[i] = b + 16'(i) * step;
  endtask

  task automatic clear_knobs();
    stall_lo = 0; stall_hi = -1; ign_cyc = 0; abort_cyc = 0; rand_rdy = 0;
  endtask

  // Issues start in cycle 0 and observes cycles 1..ncyc-1 at the falling edge.
  task automatic run(input int cnt, input logic [15:0] base, input int ncyc);
    logic        pstall;
    logic [15:0] pdata, paddr;
    latch_cnt = 0; latch_cyc = -1; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; stall_cnt = 0; stable_err = 0; pstall = 1'b0;
    pdata = '0; paddr = '0;
    acc_data.delete(); acc_addr.delete(); acc_cyc.delete();
    for (int i = 0; i < 64; i++) begin vlog[i] = 1'b0; blog[i] = 1'b0; end
    @(negedge clk);
    count = cnt[IW-1:0]; base_addr = base; start = 1'b1; out_if.ready = 1'b1;
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == ign_cyc);
      if (c == ign_cyc) count = 4'd2;
      abort = (c == abort_cyc);
      if (rand_rdy && c < 40) out_if.ready = 1'($urandom_range(0, 1));
      else out_if.ready = !(c >= stall_lo && c <= stall_hi);
      @(negedge clk);
      if (c < 64) begin vlog[c] = out_if.valid; blog[c] = busy; end
      if (dense_latch) begin latch_cnt++; latch_cyc = c; end
      if (done) begin done_cnt++; done_cyc = c; end
      if (busy) busy_cnt++;
      if (pstall && (!out_if.valid || out_if.data !== pdata || out_if.addr !== paddr))
        stable_err++;
      pstall = out_if.valid && !out_if.ready;
      pdata  = out_if.data;
      paddr  = out_if.addr;
      if (pstall) stall_cnt++;
      if (out_if.valid && out_if.ready) begin
        acc_data.push_back(out_if.data);
        acc_addr.push_back(out_if.addr);
        acc_cyc.push_back(c);
      end
    end
    start = 1'b0; abort = 1'b0; out_if.ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; count = '0; base_addr = '0;
    out_if.ready = 1'b1;
    clear_knobs();
    set_acc(16'd10, 16'd10);
    repeat (2) @(negedge clk);
    check("reset_ctrl", {busy, done, dense_latch, out_if.valid}, 4'b0000);
    check("reset_data", {dense_rd_addr, out_if.data, out_if.addr}, 36'h0);
    rst = 1'b0;

    // Basic drain: 4 words 10..40 at 0x100..0x103 in cycles 3..6, done in cycle 7.
    run(4, 16'h0100, 10);
    check("basic_latch_cnt", latch_cnt, 1);
    check("basic_latch_cyc", latch_cyc, 1);
    check("basic_nwords", acc_data.size(), 4);
    for (int i = 0; i < acc_data.size(); i++) begin
      check($sformatf("basic_data%0d", i), acc_data[i], 16'(10 * (i + 1)));
      check($sformatf("basic_addr%0d", i), acc_addr[i], 16'h0100 + 16'(i));
      check($sformatf("basic_cyc%0d", i), acc_cyc[i], 3 + i);
    end
    check("basic_done_cyc", done_cyc, 7);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_busy_cycles", busy_cnt, 7);
    check("basic_rd_addr_hold", dense_rd_addr, 4);

    // Backpressure: ready low in cycles 4-5 holds word 1 for three cycles.
    clear_knobs(); stall_lo = 4; stall_hi = 5;
    run(3, 16'h0020, 12);
    check("bp_nwords", acc_data.size(), 3);
    for (int i = 0; i < acc_data.size(); i++) begin
      check($sformatf("bp_data%0d", i), acc_data[i], 16'(10 * (i + 1)));
      check($sformatf("bp_addr%0d", i), acc_addr[i], 16'h0020 + 16'(i));
    end
    if (acc_cyc.size() == 3) check("bp_word1_cyc", acc_cyc[1], 6);
    check("bp_stall_cnt", stall_cnt, 2);
    check("bp_stable", stable_err, 0);
    check("bp_done_cyc", done_cyc, 8);

    // count = 0: done in cycle 1 with no latch and no words.
    clear_knobs();
    run(0, 16'h0000, 5);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_latch", latch_cnt, 0);
    check("zero_nwords", acc_data.size(), 0);
    check("zero_busy_cycles", busy_cnt, 1);

    // count = N_PE+3 is clamped to N_PE.
    set_acc(16'h1000, 16'h0011);
    run(NPE + 3, 16'h0500, 16);
    check("clamp_nwords", acc_data.size(), NPE);
    if (acc_data.size() == NPE) begin
      check("clamp_last_data", acc_data[NPE-1], 16'h1000 + 16'h0011 * 16'(NPE - 1));
      check("clamp_last_addr", acc_addr[NPE-1], 16'h0500 + 16'(NPE - 1));
    end
    check("clamp_done_cyc", done_cyc, NPE + 3);
    check("clamp_rd_addr_hold", dense_rd_addr, NPE);

    // Address wrap modulo 2^16.
    run(3, 16'hFFFE, 9);
    check("wrap_nwords", acc_data.size(), 3);
    if (acc_addr.size() == 3) begin
      check("wrap_addr0", acc_addr[0], 16'hFFFE);
      check("wrap_addr1", acc_addr[1], 16'hFFFF);
      check("wrap_addr2", acc_addr[2], 16'h0000);
    end

    // start with a different count during DRAIN is ignored.
    clear_knobs(); ign_cyc = 4; set_acc(16'd10, 16'd10);
    run(4, 16'h0040, 10);
    check("ign_nwords", acc_data.size(), 4);
    check("ign_latch_cnt", latch_cnt, 1);
    check("ign_done_cyc", done_cyc, 7);
    if (acc_addr.size() == 4) check("ign_last_addr", acc_addr[3], 16'h0043);

    // Abort while word 2 is stalled.
    clear_knobs(); stall_lo = 5; stall_hi = 20; abort_cyc = 6;
    run(4, 16'h0200, 9);
    check("abort_nwords", acc_data.size(), 2);
    check("abort_valid_before", vlog[6], 1'b1);
    check("abort_valid_after", vlog[7], 1'b0);
    check("abort_busy_after", blog[7], 1'b0);
    check("abort_no_done", done_cnt, 0);
    clear_knobs(); set_acc(16'h0700, 16'h0001);
    run(2, 16'h0300, 8);
    check("post_abort_done_cyc", done_cyc, 5);
    check("post_abort_nwords", acc_data.size(), 2);
    if (acc_data.size() == 2) check("post_abort_data1", acc_data[1], 16'h0701);

    // Asynchronous reset in the middle of DRAIN.
    run(8, 16'h0123, 6);
    check("rst_mid_valid_before", vlog[5], 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {busy, done, dense_latch, out_if.valid}, 4'b0000);
    check("rst_async_data", {dense_rd_addr, out_if.data, out_if.addr}, 36'h0);
    @(negedge clk); rst = 1'b0;

    // Full-array streaming with random ready.
    clear_knobs(); rand_rdy = 1; set_acc(16'hA000, 16'h0007);
    run(NPE, 16'h0800, 60);
    check("rand_nwords", acc_data.size(), NPE);
    for (int i = 0; i < acc_data.size(); i++) begin
      check($sformatf("rand_data%0d", i), acc_data[i], acc[i]);
      check($sformatf("rand_addr%0d", i), acc_addr[i], 16'h0800 + 16'(i));
    end
    check("rand_stable", stable_err, 0);
    check("rand_done_cyc", done_cyc, NPE + 3 + stall_cnt);
    check("rand_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
